data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage (CPU) and a DMA/loader requester.
- Serialises accesses and inserts WAIT_STATES extra memory cycles per access.
- Stalls the pipeline via cpu_stall until the CPU access completes.
- Guarantees DMA progress with a starvation limit on consecutive CPU grants.

Parameters:
- ADDR_WIDTH, 32, address width of both requesters and the memory port.
- DATA_WIDTH, 32, data width.
- WAIT_STATES, 1, extra cycles per access (0..7); an access occupies WAIT_STATES+1 cycles.
- STARVE_LIMIT, 4, consecutive CPU grants allowed while dma_req is pending (1..15).

Ports:
- clk  input  1  clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- cpu_req  input  1  MEM-stage access request (MemRead|MemWrite)
- cpu_we  input  1  1=write, 0=read
- cpu_addr  input  ADDR_WIDTH  CPU address
- cpu_wdata  input  DATA_WIDTH  CPU write data
- cpu_rdata  output  DATA_WIDTH  CPU read data
- cpu_stall  output  1  freeze PC/IF/ID/EX/MEM registers
- dma_req  input  1  DMA request
- dma_we  input  1  DMA write enable
- dma_addr  input  ADDR_WIDTH  DMA address
- dma_wdata  input  DATA_WIDTH  DMA write data
- dma_rdata  output  DATA_WIDTH  DMA read data
- dma_ack  output  1  one-cycle completion pulse
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_we  output  1  memory write strobe; memory writes on the clk edge
- mem_re  output  1  memory read enable
- mem_rdata  input  DATA_WIDTH  memory read data, valid combinationally while mem_re is high
- cpu_stall_cycles  output  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- States: IDLE, CPU_ACC, DMA_ACC. A 3-bit cycle counter cnt runs within the access states.
- IDLE arbitration:
  - Only cpu_req high -> CPU_ACC.
  - Only dma_req high -> DMA_ACC.
  - Both high -> CPU_ACC, unless starve_cnt == STARVE_LIMIT, in which case DMA_ACC.
  - Neither high -> stay in IDLE.
- Grant edge: the winner's addr, wdata and we are latched into internal registers; cnt is cleared.
  - mem_addr and mem_wdata always come from the latched registers. Requester input changes after the grant are ignored.
- Access cycles: cnt increments each cycle. Completion cycle is cnt == WAIT_STATES; the next state is always IDLE, so there is one arbitration cycle between accesses.
- Memory strobes:
  - mem_re is high in every access cycle of a read.
  - mem_we is high only in the completion cycle of a write, giving exactly one write per access.
  - Both are 0 in IDLE.
- cpu_stall = cpu_req & ~(state == CPU_ACC & cnt == WAIT_STATES). This is combinational, so a lone CPU access stalls for WAIT_STATES+1 cycles.
- cpu_rdata / dma_rdata:
  - Equal mem_rdata during the owner's read completion cycle.
  - Otherwise hold the owner's last completed read value.
  - Write completions do not change the held value.
- dma_ack is high only in the DMA completion cycle. The DMA must drop or renew dma_req in the following cycle.
- starve_cnt (4-bit):
  - Increments on each CPU grant made while dma_req is high.
  - Clears on a DMA grant, and in IDLE when dma_req is low.
  - Saturates at STARVE_LIMIT.
- Boundary cases:
  - Requests dropped mid-access: the access still completes.
  - cpu_req falling during CPU_ACC: no error; cpu_stall simply follows cpu_req.
- Reset values: state IDLE, cnt 0, starve_cnt 0, latched address/data 0, held rdata 0, mem_we 0, mem_re 0, dma_ack 0.
  - cpu_stall is 0 while cpu_req is low.
- Reset mid-access: the next cycle is IDLE; no write is issued for the aborted access.

Optional Feature:
- Macro: DATA_MEM_ARB_PERF_EN.
- Defined: cpu_stall_cycles counts cycles with cpu_stall high; it is cleared by reset and wraps at 2^32.
- Undefined: cpu_stall_cycles is tied to 0 and no counter logic is generated.

Test Plan:
- CPU read alone, WAIT_STATES=1, cpu_addr=0x10010004, mem_rdata=0xDEADBEEF -> cpu_stall high exactly 2 cycles, mem_re high during the 2 CPU_ACC cycles, cpu_rdata=0xDEADBEEF in the completion cycle and held afterwards.
- CPU write of 0x12345678 to 0x10010008 -> mem_we high for exactly 1 cycle with mem_addr=0x10010008 and mem_wdata=0x12345678; cpu_rdata unchanged.
- cpu_req and dma_req rise in the same IDLE cycle -> CPU served first, one IDLE cycle, then DMA served; dma_ack pulses once.
- CPU requesting continuously with dma_req held, STARVE_LIMIT=4 -> four CPU grants, then a DMA grant, after which starve_cnt=0.
- reset asserted in the first CPU_ACC cycle of a write -> IDLE next cycle, no mem_we pulse, all outputs at reset values.
- With DATA_MEM_ARB_PERF_EN defined, three CPU reads at WAIT_STATES=1 -> cpu_stall_cycles=6; with the macro undefined -> cpu_stall_cycles stays 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and a DMA requester, with wait states
// and a DMA starvation limit. Define DATA_MEM_ARB_PERF_EN to enable the stall-cycle counter.
module data_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  output logic                  o_cpu_stall,
  input  logic                  i_dma_req,
  input  logic                  i_dma_we,
  input  logic [ADDR_WIDTH-1:0] i_dma_addr,
  input  logic [DATA_WIDTH-1:0] i_dma_wdata,
  output logic [DATA_WIDTH-1:0] o_dma_rdata,
  output logic                  o_dma_ack,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_we,
  output logic                  o_mem_re,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [31:0]           o_cpu_stall_cycles
);

  typedef enum logic [1:0] {StIdle, StCpuAcc, StDmaAcc} state_e;

  localparam logic [2:0] LastCnt   = 3'(WAIT_STATES);
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  state_e                r_state, w_state_next;
  logic [2:0]            r_cnt;
  logic [3:0]            r_starve;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_dma_rdata;

  logic w_done;
  logic w_grant_cpu;
  logic w_grant_dma;
  logic w_cpu_rd_done;
  logic w_dma_rd_done;

  assign w_done        = (r_state != StIdle) && (r_cnt == LastCnt);
  assign w_cpu_rd_done = (r_state == StCpuAcc) && w_done && !r_we;
  assign w_dma_rd_done = (r_state == StDmaAcc) && w_done && !r_we;

  always_comb begin
    w_state_next = r_state;
    w_grant_cpu  = 1'b0;
    w_grant_dma  = 1'b0;
    unique case (r_state)
      StIdle: begin
        // CPU wins ties until it has used up its consecutive-grant allowance.
        if (i_cpu_req && (!i_dma_req || (r_starve != StarveMax))) begin
          w_grant_cpu  = 1'b1;
          w_state_next = StCpuAcc;
        end else if (i_dma_req) begin
          w_grant_dma  = 1'b1;
          w_state_next = StDmaAcc;
        end
      end
      StCpuAcc, StDmaAcc: begin
        if (w_done) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_starve    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_cpu || w_grant_dma) begin
        r_cnt   <= '0;
        r_addr  <= w_grant_cpu ? i_cpu_addr  : i_dma_addr;
        r_wdata <= w_grant_cpu ? i_cpu_wdata : i_dma_wdata;
        r_we    <= w_grant_cpu ? i_cpu_we    : i_dma_we;
      end else if (r_state != StIdle) begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (r_state == StIdle) begin
        if (w_grant_dma || !i_dma_req) begin
          r_starve <= '0;
        end else if (w_grant_cpu && (r_starve != StarveMax)) begin
          r_starve <= r_starve + 4'd1;
        end
      end
      if (w_cpu_rd_done) r_cpu_rdata <= i_mem_rdata;
      if (w_dma_rd_done) r_dma_rdata <= i_mem_rdata;
    end
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_re    = (r_state != StIdle) && !r_we;
  assign o_mem_we    = w_done && r_we;
  assign o_dma_ack   = (r_state == StDmaAcc) && w_done;
  assign o_cpu_stall = i_cpu_req && !((r_state == StCpuAcc) && w_done);
  assign o_cpu_rdata = w_cpu_rd_done ? i_mem_rdata : r_cpu_rdata;
  assign o_dma_rdata = w_dma_rd_done ? i_mem_rdata : r_dma_rdata;

`ifdef DATA_MEM_ARB_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cycles <= '0;
    end else if (o_cpu_stall) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_cpu_stall_cycles = r_stall_cycles;
`else
  assign o_cpu_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: table-driven single accesses plus arbitration,
// starvation, mid-access reset and stall-counter sequences, with a completion scoreboard.
module tb_data_mem_arbiter;

  localparam int unsigned WS = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_init = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata, stall_cycles;
  logic        cpu_stall, dma_ack, mem_we, mem_re;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_arr [16];

  typedef struct {
    bit          is_dma;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    bit          is_dma;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .WAIT_STATES (WS),
    .STARVE_LIMIT(4)
  ) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_cpu_req         (cpu_req),
    .i_cpu_we          (cpu_we),
    .i_cpu_addr        (cpu_addr),
    .i_cpu_wdata       (cpu_wdata),
    .o_cpu_rdata       (cpu_rdata),
    .o_cpu_stall       (cpu_stall),
    .i_dma_req         (dma_req),
    .i_dma_we          (dma_we),
    .i_dma_addr        (dma_addr),
    .i_dma_wdata       (dma_wdata),
    .o_dma_rdata       (dma_rdata),
    .o_dma_ack         (dma_ack),
    .o_mem_addr        (mem_addr),
    .o_mem_wdata       (mem_wdata),
    .o_mem_we          (mem_we),
    .o_mem_re          (mem_re),
    .i_mem_rdata       (mem_rdata),
    .o_cpu_stall_cycles(stall_cycles)
  );

  // Memory model: combinational read, write on the clock edge.
  assign mem_rdata = mem_arr[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= 32'h5A00_0000 | 32'(i);
      mem_arr[1] <= 32'hDEAD_BEEF;
    end else if (mem_we) begin
      mem_arr[mem_addr[5:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every completion must match the next expected access in order.
  always @(negedge clk) begin
    if (!reset) begin
      bit cpu_done;
      sb_t e;
      cpu_done = cpu_req && !cpu_stall;
      if (cpu_done || dma_ack) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_owner", 32'(dma_ack), 32'(e.is_dma));
          chk("sb_addr", mem_addr, e.addr);
          if (e.we) begin
            chk("sb_we", 32'(mem_we), 32'd1);
            chk("sb_wdata", mem_wdata, e.data);
          end else begin
            chk("sb_re", 32'(mem_re), 32'd1);
            chk("sb_rdata", e.is_dma ? dma_rdata : cpu_rdata, e.data);
          end
        end
      end else if (mem_we) begin
        chk("stray_mem_we", 32'd1, 32'd0);
      end
    end
  end

  task automatic do_access(input int idx, input vec_t v);
    int cyc = 0, stall_n = 0, re_n = 0, we_n = 0;
    bit done = 1'b0;
    sb_q.push_back('{v.is_dma, v.we, v.addr, v.we ? v.wdata : v.exp_rdata});
    @(posedge clk); #1;
    if (v.is_dma) begin
      dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      stall_n += int'(cpu_stall);
      re_n    += int'(mem_re);
      we_n    += int'(mem_we);
      done = v.is_dma ? dma_ack : (cpu_req && !cpu_stall);
      // Inputs changing after the grant must not reach the memory port.
      if (cyc == 2) begin
        cpu_addr = ~v.addr; cpu_wdata = ~v.wdata;
        dma_addr = ~v.addr; dma_wdata = ~v.wdata;
      end
    end
    chk($sformatf("row%0d_timeout", idx), 32'(done), 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(negedge clk);
    chk($sformatf("row%0d_latency", idx), 32'(cyc), WS + 2);
    chk($sformatf("row%0d_stall_cycles", idx), 32'(stall_n), v.is_dma ? 0 : WS + 1);
    chk($sformatf("row%0d_re_cycles", idx), 32'(re_n), v.we ? 0 : WS + 1);
    chk($sformatf("row%0d_we_pulses", idx), 32'(we_n), v.we ? 1 : 0);
    chk($sformatf("row%0d_held_rdata", idx), v.is_dma ? dma_rdata : cpu_rdata, v.exp_rdata);
    chk($sformatf("row%0d_idle_re", idx), 32'(mem_re), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n, gap, acks, we_seen;
    bit done;
    logic [5:0] pat;
    vec_t rd;

    vecs[0] = '{1'b0, 1'b0, 32'h1001_0004, 32'h0,         32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h1001_0008, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 1'b0, 32'h1001_0008, 32'h0,         32'h1234_5678};
    vecs[3] = '{1'b1, 1'b1, 32'h1001_000C, 32'hCAFE_F00D, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h1001_000C, 32'h0,         32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b0, 32'h1001_0010, 32'h0,         32'h5A00_0004};
    vecs[6] = '{1'b0, 1'b1, 32'h1001_0014, 32'h0,         32'h1234_5678};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_dma_ack", 32'(dma_ack), 32'd0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dma_rdata", dma_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);

    for (int i = 0; i < 7; i++) do_access(i, vecs[i]);

    // Reset during the first access cycle of a CPU write.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1001_0018; cpu_wdata = 32'hBADB_AD00;
    @(posedge clk); #1;
    reset = 1'b1;
    cpu_req = 1'b0;
    we_seen = 0;
    @(negedge clk);
    we_seen += int'(mem_we);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      we_seen += int'(mem_we);
    end
    chk("midrst_no_write", 32'(we_seen), 32'd0);
    chk("midrst_mem_re", 32'(mem_re), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_mem_wdata", mem_wdata, 32'd0);
    chk("midrst_cpu_rdata", cpu_rdata, 32'd0);
    chk("midrst_dma_ack", 32'(dma_ack), 32'd0);
    chk("midrst_mem_untouched", mem_arr[6], 32'h5A00_0006);

    // Three CPU reads after reset: two stall cycles each.
    rd = '{1'b0, 1'b0, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF};
    for (int i = 0; i < 3; i++) do_access(10 + i, rd);
`ifdef DATA_MEM_ARB_PERF_EN
    chk("perf_stall_cycles", stall_cycles, 32'd6);
`else
    chk("perf_stall_cycles", stall_cycles, 32'd0);
`endif

    // Simultaneous requests: CPU first, one arbitration cycle, then DMA.
    sb_q.push_back('{1'b0, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF});
    sb_q.push_back('{1'b1, 1'b0, 32'h1001_0010, 32'h5A00_0004});
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0004;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h1001_0010;
    n = 0; acks = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      acks += int'(dma_ack);
      done = cpu_req && !cpu_stall;
    end
    chk("sim_cpu_done", 32'(done), 32'd1);
    chk("sim_cpu_latency", 32'(n), WS + 2);
    chk("sim_early_ack", 32'(acks), 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    gap = 0; done = 1'b0;
    while (!done && gap < 20) begin
      @(negedge clk);
      gap++;
      if (gap == 1) chk("sim_arb_gap_re", 32'(mem_re), 32'd0);
      done = dma_ack;
    end
    chk("sim_dma_latency", 32'(gap), WS + 2);
    @(posedge clk); #1;
    dma_req = 1'b0;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      acks += int'(dma_ack);
    end
    chk("sim_extra_ack", 32'(acks), 32'd0);

    // Both requesting continuously: four CPU grants, one DMA, then CPU again.
    for (int i = 0; i < 4; i++) sb_q.push_back('{1'b0, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF});
    sb_q.push_back('{1'b1, 1'b0, 32'h1001_0010, 32'h5A00_0004});
    sb_q.push_back('{1'b0, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF});
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 32'h1001_0004;
    dma_req = 1'b1; dma_addr = 32'h1001_0010;
    n = 0; gap = 0; pat = '0;
    while (n < 6 && gap < 100) begin
      @(negedge clk);
      gap++;
      if ((cpu_req && !cpu_stall) || dma_ack) begin
        pat[n] = dma_ack;
        n++;
      end
    end
    chk("starve_completions", 32'(n), 32'd6);
    chk("starve_pattern", 32'(pat), 32'b01_0000);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
